// File: rtl/audio_capture_sequencer.sv
// Capture sequencer between the codec sample FIFO and the capture FIFO.
// Arms on start, triggers on magnitude, forwards a fixed number of samples.
module audio_capture_sequencer #(
  parameter int DATA_W      = 16,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_SMP = 48000,
  parameter int OVR_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] trig_thresh,
  input  logic [CNT_W-1:0]  cap_len,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid,
  output logic              src_ready,
  output logic [DATA_W-1:0] cap_data,
  output logic              cap_valid,
  input  logic              cap_ready,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [CNT_W-1:0]  smp_count,
  output logic [OVR_W-1:0]  ovr_count,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAPTURE = 3'd2,
    DONE    = 3'd3,
    TIMEOUT = 3'd4
  } state_t;

  localparam logic [DATA_W:0]  ONE_M   = 1;
  localparam logic [CNT_W-1:0] ONE_C   = 1;
  localparam logic [OVR_W-1:0] ONE_O   = 1;
  localparam logic [CNT_W-1:0] MAX_LEN = '1;
  localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT_SMP);

  state_t             state, state_n;
  logic [CNT_W-1:0]   smp_n;
  logic [OVR_W-1:0]   ovr_n;
  logic [CNT_W-1:0]   wait_cnt, wait_n;
  logic               ready_q;

  logic [DATA_W:0]    sext, mag, thr;
  logic               hit;
  logic [CNT_W-1:0]   eff_len;
  logic [CNT_W-1:0]   smp_inc;
  logic [CNT_W-1:0]   wait_inc;
  logic               last;

  // One extra bit so the most negative sample has a representable magnitude.
  assign sext = {src_data[DATA_W-1], src_data};
  assign mag  = src_data[DATA_W-1] ? (~sext + ONE_M) : sext;
  assign thr  = {1'b0, trig_thresh};
  assign hit  = src_valid && (mag >= thr);

  assign eff_len  = (cap_len == '0) ? MAX_LEN : cap_len;
  assign smp_inc  = smp_count + ONE_C;
  assign wait_inc = wait_cnt + ONE_C;
  assign last     = smp_inc >= eff_len;

  assign cap_data  = src_data;
  assign cap_valid = src_valid && !abort &&
                     ((state == ARMED && hit) || state == CAPTURE);

  assign src_ready = ready_q;
  assign busy      = (state == ARMED) || (state == CAPTURE);
  assign done      = (state == DONE);
  assign timed_out = (state == TIMEOUT);
  assign state_o   = state;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      smp_count <= '0;
      ovr_count <= '0;
      wait_cnt  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state     <= state_n;
      smp_count <= smp_n;
      ovr_count <= ovr_n;
      wait_cnt  <= wait_n;
      ready_q   <= 1'b1;
    end
  end

  // Next state and counter updates; abort overrides every other event.
  always_comb begin
    state_n = state;
    smp_n   = smp_count;
    ovr_n   = ovr_count;
    wait_n  = wait_cnt;
    // A forwarded slot always consumes a sample, transferred or dropped.
    if (cap_valid) begin
      smp_n = smp_inc;
      if (!cap_ready && !(&ovr_count)) ovr_n = ovr_count + ONE_O;
    end
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE, DONE, TIMEOUT: begin
          if (start) begin
            state_n = ARMED;
            smp_n   = '0;
            ovr_n   = '0;
            wait_n  = '0;
          end
        end
        ARMED: begin
          if (hit) begin
            state_n = last ? DONE : CAPTURE;
          end else if (src_valid) begin
            wait_n = wait_inc;
            if (wait_inc >= TO_C) state_n = TIMEOUT;
          end
        end
        CAPTURE: begin
          if (src_valid && last) state_n = DONE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
